// File: rtl/n_channel_handshake_demux_pkg.sv
// Shared constants and channel-state encoding for the n-channel handshake demux.
package n_channel_demux_pkg;

  localparam int MAX_CHANNELS = 16;
  localparam int DROP_W       = 8;

  typedef enum logic [0:0] {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/n_channel_handshake_demux_if.sv
// Producer/consumer bundle of the demux. Handshake: a word moves on a rising
// clock edge when its valid and ready are both 1; valid never waits on ready.
interface n_channel_handshake_demux_if
  import n_channel_demux_pkg::*;
#(
  parameter int BITS     = 4,
  parameter int CHANNELS = 4
);

  localparam int SEL_W = $clog2(CHANNELS);

  logic [BITS-1:0]          data;
  logic [SEL_W-1:0]         select;
  logic                     broadcast;
  logic                     in_valid;
  logic                     in_ready;
  logic [CHANNELS*BITS-1:0] out_data;
  logic [CHANNELS-1:0]      out_valid;
  logic [CHANNELS-1:0]      out_ready;
  logic [DROP_W-1:0]        drop_count;

  modport master (
    output data, select, broadcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, drop_count
  );

  modport slave (
    input  data, select, broadcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, drop_count
  );

endinterface

// File: rtl/n_channel_handshake_demux_channel_slot.sv
// One output channel: a single holding register with a two-state EMPTY/FULL FSM.
module demux_channel_slot
  import n_channel_demux_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr,
  input  logic [BITS-1:0] wdata,
  input  logic            ready,
  output logic [BITS-1:0] rdata,
  output logic            free,
  output ch_state_e       state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CH_EMPTY;
      rdata <= '0;
    end else if (wr) begin
      // A write while draining replaces the outgoing word, sustaining 1 word/cycle.
      state <= CH_FULL;
      rdata <= wdata;
    end else if (ready) begin
      state <= CH_EMPTY;
    end
  end

  assign free = (state == CH_EMPTY) | ready;

endmodule

// File: rtl/n_channel_handshake_demux.sv
// Registered 1-to-CHANNELS valid/ready demux with broadcast, drop counting and
// optional zeroing of idle output slices.
module n_channel_handshake_demux
  import n_channel_demux_pkg::*;
#(
  parameter int BITS      = 4,
  parameter int CHANNELS  = 4,
  parameter int ZERO_IDLE = 1,
  parameter int SEL_W     = $clog2(CHANNELS)
) (
  input logic                        clk,
  input logic                        rst_n,
  n_channel_handshake_demux_if.slave bus
);

  localparam int NSEL = 1 << SEL_W;

  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] wr;
  logic [NSEL-1:0]     free_pad;
  logic                in_range;
  logic                xfer;
  logic                drop_xfer;
  logic [DROP_W-1:0]   drop_cnt;
  ch_state_e           st [CHANNELS];
  logic [BITS-1:0]     hold [CHANNELS];

  generate
    if (NSEL == CHANNELS) begin : g_pow2
      assign in_range = 1'b1;
    end else begin : g_npow2
      localparam logic [SEL_W:0] CH_L = CHANNELS[SEL_W:0];
      assign in_range = ({1'b0, bus.select} < CH_L);
    end
  endgenerate

  // Pad so an out-of-range select never indexes past the real channels.
  always_comb begin
    free_pad                 = '0;
    free_pad[CHANNELS-1:0]   = free;
  end

  assign bus.in_ready = rst_n & (bus.broadcast ? (&free)
                                               : (in_range ? free_pad[bus.select] : 1'b1));
  assign xfer         = bus.in_valid & bus.in_ready;
  assign drop_xfer    = xfer & ~bus.broadcast & ~in_range;

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_ch
      assign wr[k] = xfer & (bus.broadcast | (in_range & (bus.select == SEL_W'(k))));

      demux_channel_slot #(.BITS(BITS)) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr[k]),
        .wdata (bus.data),
        .ready (bus.out_ready[k]),
        .rdata (hold[k]),
        .free  (free[k]),
        .state (st[k])
      );

      assign bus.out_valid[k] = (st[k] == CH_FULL);

      if (ZERO_IDLE != 0) begin : g_zero
        assign bus.out_data[k*BITS +: BITS] = (st[k] == CH_FULL) ? hold[k] : '0;
      end else begin : g_hold
        assign bus.out_data[k*BITS +: BITS] = hold[k];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_xfer && (drop_cnt != {DROP_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign bus.drop_count = drop_cnt;

endmodule

// File: tb/tb_n_channel_handshake_demux.sv
// Directed bench: a = 4ch zero-idle, b = 5ch (out-of-range selects), c = 4ch hold-last.
module tb_n_channel_handshake_demux;
  import n_channel_demux_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [7:0] exp_q[$];

  n_channel_handshake_demux_if #(.BITS(8), .CHANNELS(4)) ia ();
  n_channel_handshake_demux_if #(.BITS(8), .CHANNELS(5)) ib ();
  n_channel_handshake_demux_if #(.BITS(8), .CHANNELS(4)) ic ();

  n_channel_handshake_demux #(.BITS(8), .CHANNELS(4), .ZERO_IDLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave));
  n_channel_handshake_demux #(.BITS(8), .CHANNELS(5), .ZERO_IDLE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave));
  n_channel_handshake_demux #(.BITS(8), .CHANNELS(4), .ZERO_IDLE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ic.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ia.data = '0; ia.select = '0; ia.broadcast = 1'b0; ia.in_valid = 1'b0; ia.out_ready = '0;
    ib.data = '0; ib.select = '0; ib.broadcast = 1'b0; ib.in_valid = 1'b0; ib.out_ready = '0;
    ic.data = '0; ic.select = '0; ic.broadcast = 1'b0; ic.in_valid = 1'b0; ic.out_ready = '0;
  endtask

  task automatic drain_all();
    ia.in_valid = 1'b0; ib.in_valid = 1'b0; ic.in_valid = 1'b0;
    ia.out_ready = '1; ib.out_ready = '1; ic.out_ready = '1;
    tick();
    ia.out_ready = '0; ib.out_ready = '0; ic.out_ready = '0;
  endtask

  task automatic send_a(input logic [1:0] sel, input logic [7:0] d);
    ia.select = sel; ia.data = d; ia.broadcast = 1'b0; ia.in_valid = 1'b1;
    tick();
    ia.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    #3;
    checks++;
    if (ia.out_valid !== 4'b0000 || ia.out_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_out: valid=%b data=%h required valid=0000 data=0", ia.out_valid, ia.out_data);
    end
    checks++;
    if (ia.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 0", ia.in_ready);
    end
    checks++;
    if (ib.drop_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_drop: got %0d required 0", ib.drop_count);
    end
    #9 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unicast_stream();
    int bad_rdy;
    bad_rdy = 0;
    ia.out_ready = 4'b1111;
    ia.select = 2'd1;
    ia.in_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      ia.data = 8'(i);
      exp_q.push_back(8'(i));
      #1;
      if (ia.in_ready !== 1'b1) bad_rdy++;
      @(posedge clk);
      #1;
      checks++;
      if (ia.out_valid !== 4'b0010 || ia.out_data[15:8] !== exp_q[0]) begin
        failures++;
        $display("FAIL stream_word%0d: valid=%b data=%h required valid=0010 data=%h",
                 i, ia.out_valid, ia.out_data[15:8], exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    ia.in_valid = 1'b0;
    checks++;
    if (bad_rdy !== 0) begin
      failures++;
      $display("FAIL stream_in_ready: %0d cycles low required 0", bad_rdy);
    end
    tick();
    checks++;
    if (ia.out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL stream_drained: valid=%b required 0000", ia.out_valid);
    end
    ia.out_ready = '0;
  endtask

  task automatic test_backpressure();
    ia.out_ready = 4'b0000;
    send_a(2'd0, 8'hAA);
    ia.select = 2'd0; ia.data = 8'h55; ia.in_valid = 1'b1;
    #1;
    checks++;
    if (ia.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_blocked: in_ready=%b required 0", ia.in_ready);
    end
    tick();
    checks++;
    if (ia.out_valid !== 4'b0001 || ia.out_data[7:0] !== 8'hAA) begin
      failures++;
      $display("FAIL bp_stable: valid=%b ch0=%h required valid=0001 ch0=aa", ia.out_valid, ia.out_data[7:0]);
    end
    ia.select = 2'd3;
    #1;
    checks++;
    if (ia.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_other_ready: in_ready=%b required 1", ia.in_ready);
    end
    @(posedge clk);
    #1;
    ia.in_valid = 1'b0;
    checks++;
    if (ia.out_valid !== 4'b1001 || ia.out_data[31:24] !== 8'h55 || ia.out_data[7:0] !== 8'hAA) begin
      failures++;
      $display("FAIL bp_isolation: valid=%b data=%h required valid=1001 data=550000aa", ia.out_valid, ia.out_data);
    end
    drain_all();
  endtask

  task automatic test_broadcast();
    send_a(2'd2, 8'h22);
    ia.broadcast = 1'b1; ia.data = 8'h7E; ia.select = 2'd0; ia.in_valid = 1'b1;
    #1;
    checks++;
    if (ia.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bcast_blocked: in_ready=%b required 0", ia.in_ready);
    end
    tick();
    checks++;
    if (ia.out_valid !== 4'b0100 || ia.out_data[23:16] !== 8'h22) begin
      failures++;
      $display("FAIL bcast_no_partial: valid=%b ch2=%h required valid=0100 ch2=22", ia.out_valid, ia.out_data[23:16]);
    end
    ia.out_ready = 4'b0100;
    #1;
    checks++;
    if (ia.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bcast_release: in_ready=%b required 1", ia.in_ready);
    end
    @(posedge clk);
    #1;
    ia.in_valid = 1'b0; ia.broadcast = 1'b0; ia.out_ready = '0;
    checks++;
    if (ia.out_valid !== 4'b1111 || ia.out_data !== 32'h7E7E7E7E) begin
      failures++;
      $display("FAIL bcast_all: valid=%b data=%h required valid=1111 data=7e7e7e7e", ia.out_valid, ia.out_data);
    end
    drain_all();
  endtask

  task automatic test_zero_idle();
    ia.select = 2'd0; ia.data = 8'hF0; ia.in_valid = 1'b1;
    ic.select = 2'd0; ic.data = 8'hF0; ic.in_valid = 1'b1;
    tick();
    ia.in_valid = 1'b0; ic.in_valid = 1'b0;
    checks++;
    if (ia.out_data[7:0] !== 8'hF0 || ic.out_data[7:0] !== 8'hF0) begin
      failures++;
      $display("FAIL zi_loaded: a=%h c=%h required f0 f0", ia.out_data[7:0], ic.out_data[7:0]);
    end
    ia.out_ready = 4'b0001; ic.out_ready = 4'b0001;
    tick();
    ia.out_ready = '0; ic.out_ready = '0;
    checks++;
    if (ia.out_valid[0] !== 1'b0 || ia.out_data[7:0] !== 8'h00) begin
      failures++;
      $display("FAIL zi_zeroed: valid0=%b ch0=%h required 0 00", ia.out_valid[0], ia.out_data[7:0]);
    end
    checks++;
    if (ic.out_valid[0] !== 1'b0 || ic.out_data[7:0] !== 8'hF0) begin
      failures++;
      $display("FAIL zi_held: valid0=%b ch0=%h required 0 f0", ic.out_valid[0], ic.out_data[7:0]);
    end
  endtask

  task automatic test_out_of_range();
    int bad_rdy;
    int bad_vld;
    bad_rdy = 0;
    bad_vld = 0;
    ib.select = 3'd6; ib.broadcast = 1'b0; ib.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ib.data = 8'(i);
      #1;
      if (ib.in_ready !== 1'b1) bad_rdy++;
      @(posedge clk);
      #1;
      if (ib.out_valid !== 5'b00000) bad_vld++;
      if (i == 0) begin
        checks++;
        if (ib.drop_count !== 8'd1) begin
          failures++;
          $display("FAIL oor_first_drop: got %0d required 1", ib.drop_count);
        end
      end
    end
    ib.in_valid = 1'b0;
    checks++;
    if (bad_rdy !== 0) begin
      failures++;
      $display("FAIL oor_in_ready: %0d cycles low required 0", bad_rdy);
    end
    checks++;
    if (bad_vld !== 0) begin
      failures++;
      $display("FAIL oor_out_valid: %0d cycles nonzero required 0", bad_vld);
    end
    checks++;
    if (ib.drop_count !== 8'd255) begin
      failures++;
      $display("FAIL oor_saturate: got %0d required 255", ib.drop_count);
    end
  endtask

  task automatic test_reset_mid();
    ia.out_ready = '0;
    for (int ch = 0; ch < 4; ch++) send_a(2'(ch), 8'(8'h10 + ch));
    checks++;
    if (ia.out_valid !== 4'b1111 || ia.out_data !== 32'h13121110) begin
      failures++;
      $display("FAIL rmid_filled: valid=%b data=%h required 1111 13121110", ia.out_valid, ia.out_data);
    end
    ia.select = 2'd2; ia.data = 8'h3C; ia.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ia.out_valid !== 4'b0000 || ia.out_data !== 32'h0 || ib.drop_count !== 8'd0) begin
      failures++;
      $display("FAIL rmid_cleared: valid=%b data=%h drop=%0d required 0000 0 0",
               ia.out_valid, ia.out_data, ib.drop_count);
    end
    checks++;
    if (ia.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rmid_in_ready: got %b required 0", ia.in_ready);
    end
    #2 rst_n = 1'b1;
    tick();
    ia.in_valid = 1'b0;
    checks++;
    if (ia.out_valid !== 4'b0100 || ia.out_data[23:16] !== 8'h3C) begin
      failures++;
      $display("FAIL rmid_first_xfer: valid=%b ch2=%h required 0100 3c", ia.out_valid, ia.out_data[23:16]);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_unicast_stream();
    test_backpressure();
    test_broadcast();
    test_zero_idle();
    test_out_of_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/n_channel_handshake_demux.md
Name: n_channel_handshake_demux

Overview:
Registered 1-to-CHANNELS demultiplexer with valid/ready flow control. It generalises the combinational 2-bit-select four-way N-bit demux in width, channel count and mode. It adds per-channel output buffering, backpressure, a broadcast mode and out-of-range select handling. It sits between a single producer (e.g. a writeback/result bus) and several independent consumers that may stall.

Parameters:
BITS, 4, data width per channel
CHANNELS, 4, number of output channels (2..16)
ZERO_IDLE, 1, 1: OUT_DATA of a channel reads 0 whenever its OUT_VALID is 0; 0: holds the last delivered word
SEL_W, $clog2(CHANNELS), select width (derived, not overridden)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
DATA  in  BITS  input word
SELECT  in  SEL_W  destination channel index
BROADCAST  in  1  1: deliver word to all channels; SELECT ignored
IN_VALID  in  1  producer offers DATA
IN_READY  out  1  demux accepts this cycle (transfer = IN_VALID & IN_READY)
OUT_DATA  out  CHANNELS*BITS  channel k at [k*BITS +: BITS]
OUT_VALID  out  CHANNELS  per-channel word present
OUT_READY  in  CHANNELS  per-channel consumer accepts
DROP_COUNT  out  8  saturating count of words dropped for out-of-range SELECT

Behaviour:
- Reset, asynchronous on RST_N low: OUT_VALID=0, all channel registers=0, OUT_DATA=0, DROP_COUNT=0. Reset asserted mid-transfer discards all buffered words, with no partial state. IN_READY is 0 while RST_N is low.
- Each channel has one holding register plus a valid bit, acting as a 2-state FSM per channel:
  - EMPTY -> FULL on a write.
  - FULL -> EMPTY on OUT_READY[k] with no write.
  - FULL -> FULL on OUT_READY[k] with a simultaneous write (the new word replaces the drained one, so a same-cycle drain-and-refill sustains 1 word/cycle).
- Channel k can take a word this cycle when: free[k] = ~OUT_VALID[k] | OUT_READY[k].
- Unicast (BROADCAST=0, SELECT<CHANNELS): IN_READY=free[SELECT]. On transfer the word is written to channel SELECT only.
- Broadcast (BROADCAST=1): IN_READY = AND of all free[k]. On transfer the word is written to every channel in the same cycle. There are no partial broadcasts.
- Out-of-range (BROADCAST=0, SELECT>=CHANNELS, only possible when CHANNELS is not a power of 2): IN_READY=1 and the word is dropped. DROP_COUNT increments by 1 per such transfer and saturates at 255. No OUT_VALID changes.
- Latency: input transfer in cycle t -> OUT_VALID visible in cycle t+1. Minimum latency 1, maximum throughput 1 word/cycle per channel.
- IN_READY is combinational from SELECT, BROADCAST, OUT_VALID and OUT_READY. There is no combinational path from IN_VALID to IN_READY.
- Output path:
  - OUT_VALID and the channel registers come directly from flops.
  - OUT_DATA slice k = register k when ZERO_IDLE=0.
  - OUT_DATA slice k = register k when OUT_VALID[k] is 1 and 0 otherwise when ZERO_IDLE=1. This is the only output gating.
- Stability: once OUT_VALID[k]=1, the slice holds until OUT_READY[k]=1. Channels are fully independent; a stalled channel never blocks unicast traffic to others.
- Producer may change SELECT/DATA while IN_READY=0. The value held when the transfer occurs is the one used.

Decomposition:
- Package n_channel_demux_pkg: MAX_CHANNELS=16 constant, DROP_W=8 constant, channel-state enum {CH_EMPTY, CH_FULL}.
- One sub-module, demux_channel_slot: a single holding register plus valid, with write/ready/free logic. Instantiated CHANNELS times in a generate loop.
- Top level holds select decode, broadcast AND-reduction, drop counter and ZERO_IDLE gating.

Test Plan:
- Reset mid-operation: fill all 4 channels (CHANNELS=4, BITS=8), pulse RST_N low asynchronously between edges -> OUT_VALID=4'b0000, OUT_DATA=0, DROP_COUNT=0 immediately. First post-reset transfer of 0x3C to SELECT=2 -> OUT_VALID=4'b0100 next cycle.
- Unicast streaming: SELECT=1, words 0x01..0x10 back-to-back, OUT_READY=4'b1111 -> IN_READY held 1, channel 1 delivers 16 words in order at 1/cycle, other OUT_VALID stay 0.
- Backpressure isolation: channel 0 full with 0xAA, OUT_READY[0]=0, send 0x55 to channel 0 -> IN_READY=0 and 0xAA is stable. Switch SELECT=3 -> IN_READY=1 and 0x55 appears on channel 3.
- Broadcast: channel 2 full and stalled, BROADCAST=1, DATA=0x7E -> IN_READY=0. Release OUT_READY[2] -> same-cycle transfer, next cycle OUT_VALID=4'b1111, all slices 0x7E.
- Out-of-range: CHANNELS=5, SELECT=6, 300 valid words -> IN_READY=1 every cycle, OUT_VALID unchanged, DROP_COUNT=255 (saturated).
- ZERO_IDLE: ZERO_IDLE=1, drain channel 0 after 0xF0 -> slice reads 0x00. With ZERO_IDLE=0 the same sequence leaves the slice at 0xF0 with OUT_VALID[0]=0.
